// File: rtl/tl_ul_port_buffer.sv
// TL-UL A/D channel buffer stage: two independent FIFOs that register valid/ready between core port and fabric.
// Optional macro TL_UL_PORT_BUFFER_FLOW_EN enables 0-cycle flow-through when a FIFO is empty.
module tl_ul_port_buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             accept_en;
  logic             enq;
  logic             deq;
  logic             bypass;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // accept_en keeps in_ready low through reset cycles without a combinational path from reset
  assign in_ready = accept_en & (count != FULL_COUNT);
  assign empty    = (count == '0);
  assign enq      = in_valid & in_ready;

`ifdef TL_UL_PORT_BUFFER_FLOW_EN
  assign out_valid = ~empty | enq;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign bypass    = empty & enq & out_ready;
`else
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign bypass    = 1'b0;
`endif

  assign deq = out_valid & out_ready;

  // occupancy update; simultaneous enq/deq (including bypass) leaves count unchanged
  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // storage, pointers and occupancy state
  always_ff @(posedge clock) begin
    if (!reset) begin
      accept_en <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      accept_en <= 1'b1;
      count     <= count_next;
      if (enq && !bypass) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (deq && !bypass) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end
endmodule

module tl_ul_port_buffer #(
  parameter int ADDR_W = 30,
  parameter int SRC_W  = 1,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_in_valid,
  output logic              a_in_ready,
  input  logic [2:0]        a_in_opcode,
  input  logic [2:0]        a_in_param,
  input  logic [1:0]        a_in_size,
  input  logic [SRC_W-1:0]  a_in_source,
  input  logic [ADDR_W-1:0] a_in_address,
  input  logic [3:0]        a_in_mask,
  input  logic [31:0]       a_in_data,
  output logic              a_out_valid,
  input  logic              a_out_ready,
  output logic [2:0]        a_out_opcode,
  output logic [2:0]        a_out_param,
  output logic [1:0]        a_out_size,
  output logic [SRC_W-1:0]  a_out_source,
  output logic [ADDR_W-1:0] a_out_address,
  output logic [3:0]        a_out_mask,
  output logic [31:0]       a_out_data,
  input  logic              d_in_valid,
  output logic              d_in_ready,
  input  logic [2:0]        d_in_opcode,
  input  logic [1:0]        d_in_param,
  input  logic [1:0]        d_in_size,
  input  logic [SRC_W-1:0]  d_in_source,
  input  logic              d_in_sink,
  input  logic              d_in_denied,
  input  logic              d_in_corrupt,
  input  logic [31:0]       d_in_data,
  output logic              d_out_valid,
  input  logic              d_out_ready,
  output logic [2:0]        d_out_opcode,
  output logic [1:0]        d_out_param,
  output logic [1:0]        d_out_size,
  output logic [SRC_W-1:0]  d_out_source,
  output logic              d_out_sink,
  output logic              d_out_denied,
  output logic              d_out_corrupt,
  output logic [31:0]       d_out_data,
  output logic              idle
);
  localparam int A_W = 3 + 3 + 2 + SRC_W + ADDR_W + 4 + 32;
  localparam int D_W = 3 + 2 + 2 + SRC_W + 1 + 1 + 1 + 32;

  logic [A_W-1:0] a_in_beat;
  logic [A_W-1:0] a_out_beat;
  logic [D_W-1:0] d_in_beat;
  logic [D_W-1:0] d_out_beat;
  logic           a_empty;
  logic           d_empty;

  assign a_in_beat = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                      a_in_address, a_in_mask, a_in_data};
  assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
          a_out_address, a_out_mask, a_out_data} = a_out_beat;

  assign d_in_beat = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                      d_in_sink, d_in_denied, d_in_corrupt, d_in_data};
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
          d_out_sink, d_out_denied, d_out_corrupt, d_out_data} = d_out_beat;

  tl_ul_port_buffer_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_beat),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_beat),
    .empty     (a_empty)
  );

  tl_ul_port_buffer_fifo #(.WIDTH(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_data   (d_in_beat),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_data  (d_out_beat),
    .empty     (d_empty)
  );

  assign idle = a_empty & d_empty;
endmodule
